cam_scaler: RTL and testbench

Registered, parametrised integer upscaler between the camera frame buffer and the video output pipeline. It generates frame-buffer read addresses from the display raster position and returns either the fetched camera pixel or a border colour. Scale factor is 1x–4x and is latched only at frame boundaries. Address generation uses counters only: no dividers, no multipliers.

---
 rtl/cam_scaler.sv | 215 +++++++++++++++++++++
 tb/tb_cam_scaler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cam_scaler.sv
// cam_scaler: registered 1x-4x integer upscaler between a camera frame
// buffer and the video output pipeline. Read addresses come from the display
// raster position using counters only. Scale, border colour and lock state
// are latched on frame_start_in.
// Optional build macro: CAM_SCALER_MIRROR_EN adds a horizontally mirrored
// ("selfie") address path. When it is not defined, mirror_in is ignored.
module cam_scaler #(
    parameter int SRC_W  = 240,
    parameter int SRC_H  = 320,
    parameter int PW     = 16,
    parameter int AW     = 17,
    parameter int RD_LAT = 2
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          frame_start_in,
    input  logic          active_in,
    input  logic [10:0]   hcount_in,
    input  logic [1:0]    scale_in,
    input  logic [PW-1:0] border_in,
    input  logic          mirror_in,
    output logic [AW-1:0] addr_out,
    input  logic [PW-1:0] pixel_in,
    output logic [PW-1:0] pixel_out,
    output logic          valid_out,
    output logic          in_window_out,
    output logic [1:0]    scale_out
);

    localparam int HW = $clog2(SRC_W + 1);
    localparam int VW = $clog2(SRC_H + 1);

    // Latched frame state. The scale code equals k-1, so it is also the
    // wrap value of both sub-pixel counters.
    logic [1:0]    scale_q, scale_d;
    logic [PW-1:0] border_q, border_d;
    logic          locked_q, locked_d;
    logic          seen_line_q, seen_line_d;

    // Raster-to-source counters
    logic [1:0]    hsub_q, hsub_d;
    logic [1:0]    vsub_q, vsub_d;
    logic [HW-1:0] hsrc_q, hsrc_d;
    logic [VW-1:0] vsrc_q, vsrc_d;
    logic [AW-1:0] line_base_q, line_base_d;

    // Stage 1 and the delay line that covers the frame-buffer read latency
    logic [AW-1:0]     addr_q, addr_d;
    logic              win_s1_q, win_s1_d;
    logic              act_s1_q, act_s1_d;
    logic [RD_LAT-1:0] win_dly_q, win_dly_d;
    logic [RD_LAT-1:0] act_dly_q, act_dly_d;

    // Output stage
    logic [PW-1:0] pixel_q, pixel_d;
    logic          valid_q, valid_d;
    logic          in_window_q, in_window_d;

    logic          line_start;
    logic [AW-1:0] col_addr;

`ifdef CAM_SCALER_MIRROR_EN
    logic mirror_q, mirror_d;
`else
    logic unused_mirror;
    assign unused_mirror = mirror_in;
`endif

    assign line_start = active_in && (hcount_in == '0);

    // Frame latch and raster counters; the frame latch overrides counting
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        scale_d     = scale_q;
        border_d    = border_q;
        locked_d    = locked_q;
        seen_line_d = seen_line_q;
        hsub_d      = hsub_q;
        vsub_d      = vsub_q;
        hsrc_d      = hsrc_q;
        vsrc_d      = vsrc_q;
        line_base_d = line_base_q;
`ifdef CAM_SCALER_MIRROR_EN
        mirror_d    = mirror_q;
`endif
        if (frame_start_in) begin
            scale_d     = scale_in;
            border_d    = border_in;
            locked_d    = 1'b1;
`ifdef CAM_SCALER_MIRROR_EN
            mirror_d    = mirror_in;
`endif
            hsub_d      = '0;
            vsub_d      = '0;
            hsrc_d      = '0;
            vsrc_d      = '0;
            line_base_d = '0;
            // A coincident line start is line 0 of the new frame
            seen_line_d = line_start;
        end else if (active_in) begin
            if (hcount_in == '0) begin
                hsub_d = '0;
                hsrc_d = '0;
                // The first line start of a frame is line 0: no vertical step
                if (seen_line_q) begin
                    if (vsub_q == scale_q) begin
                        vsub_d = '0;
                        if (vsrc_q < VW'(SRC_H)) begin
                            vsrc_d      = vsrc_q + VW'(1);
                            line_base_d = line_base_q + AW'(SRC_W);
                        end
                    end else begin
                        vsub_d = vsub_q + 2'd1;
                    end
                end
                seen_line_d = 1'b1;
            end else if (hsub_q == scale_q) begin
                hsub_d = '0;
                if (hsrc_q < HW'(SRC_W)) begin
                    hsrc_d = hsrc_q + HW'(1);
                end
            end else begin
                hsub_d = hsub_q + 2'd1;
            end
        end
    end

    // Stage 1: window decision and read address from this cycle's counters
    always_comb begin
        win_s1_d = locked_d && (hsrc_d < HW'(SRC_W)) && (vsrc_d < VW'(SRC_H));
        act_s1_d = active_in;
`ifdef CAM_SCALER_MIRROR_EN
        col_addr = mirror_d ? (AW'(SRC_W - 1) - AW'(hsrc_d)) : AW'(hsrc_d);
`else
        col_addr = AW'(hsrc_d);
`endif
        // Outside the window the address holds, so the frame buffer sees no spurious reads
        addr_d = win_s1_d ? (line_base_d + col_addr) : addr_q;
    end

    // Delay window and data-enable by the frame-buffer read latency
    always_comb begin
        win_dly_d    = win_dly_q;
        act_dly_d    = act_dly_q;
        win_dly_d[0] = win_s1_q;
        act_dly_d[0] = act_s1_q;
        for (int i = 1; i < RD_LAT; i++) begin
            win_dly_d[i] = win_dly_q[i-1];
            act_dly_d[i] = act_dly_q[i-1];
        end
    end

    // Output stage: camera pixel inside the window, latched border outside
    always_comb begin
        in_window_d = win_dly_q[RD_LAT-1];
        valid_d     = act_dly_q[RD_LAT-1];
        pixel_d     = in_window_d ? pixel_in : border_q;
    end

    // State register; reset discards the whole pipeline at once
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the delay-line vectors are reset too, so no stale pixel escapes after reset.
            scale_q     <= '0;
            border_q    <= '0;
            locked_q    <= 1'b0;
            seen_line_q <= 1'b0;
            hsub_q      <= '0;
            vsub_q      <= '0;
            hsrc_q      <= '0;
            vsrc_q      <= '0;
            line_base_q <= '0;
            addr_q      <= '0;
            win_s1_q    <= 1'b0;
            act_s1_q    <= 1'b0;
            win_dly_q   <= '0;
            act_dly_q   <= '0;
            pixel_q     <= '0;
            valid_q     <= 1'b0;
            in_window_q <= 1'b0;
`ifdef CAM_SCALER_MIRROR_EN
            mirror_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            scale_q     <= scale_d;
            border_q    <= border_d;
            locked_q    <= locked_d;
            seen_line_q <= seen_line_d;
            hsub_q      <= hsub_d;
            vsub_q      <= vsub_d;
            hsrc_q      <= hsrc_d;
            vsrc_q      <= vsrc_d;
            line_base_q <= line_base_d;
            addr_q      <= addr_d;
            win_s1_q    <= win_s1_d;
            act_s1_q    <= act_s1_d;
            win_dly_q   <= win_dly_d;
            act_dly_q   <= act_dly_d;
            pixel_q     <= pixel_d;
            valid_q     <= valid_d;
            in_window_q <= in_window_d;
`ifdef CAM_SCALER_MIRROR_EN
            mirror_q    <= mirror_d;
`endif
        end
    end

    assign addr_out      = addr_q;
    assign pixel_out     = pixel_q;
    assign valid_out     = valid_q;
    assign in_window_out = in_window_q;
    assign scale_out     = scale_q;

endmodule

// File: tb/tb_cam_scaler.sv
// Scoreboard bench for cam_scaler. Stimulus pushes the expected window flag,
// pixel and issue cycle; a negedge monitor pops one entry per valid_out.
// The frame buffer model returns data = address with a 2-cycle read latency.
`timescale 1ns/1ps
module tb_cam_scaler;

    localparam int SRC_W  = 240;
    localparam int SRC_H  = 320;
    localparam int PW     = 16;
    localparam int AW     = 17;
    localparam int RD_LAT = 2;
    localparam int LAT    = RD_LAT + 2;
`ifdef CAM_SCALER_MIRROR_EN
    localparam bit MIR_BUILT = 1'b1;
`else
    localparam bit MIR_BUILT = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start_in = 1'b0;
    logic          active_in = 1'b0;
    logic [10:0]   hcount_in = '0;
    logic [1:0]    scale_in = '0;
    logic [PW-1:0] border_in = '0;
    logic          mirror_in = 1'b0;
    logic [AW-1:0] addr_out;
    logic [PW-1:0] pixel_in;
    logic [PW-1:0] pixel_out;
    logic          valid_out;
    logic          in_window_out;
    logic [1:0]    scale_out;

    cam_scaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .PW(PW), .AW(AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .frame_start_in(frame_start_in),
        .active_in     (active_in),
        .hcount_in     (hcount_in),
        .scale_in      (scale_in),
        .border_in     (border_in),
        .mirror_in     (mirror_in),
        .addr_out      (addr_out),
        .pixel_in      (pixel_in),
        .pixel_out     (pixel_out),
        .valid_out     (valid_out),
        .in_window_out (in_window_out),
        .scale_out     (scale_out)
    );

    always #5 clk_in = ~clk_in;

    // Frame buffer model: data = address, RD_LAT = 2 cycles
    logic [AW-1:0] fb1, fb2;
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            fb1 <= '0;
            fb2 <= '0;
        end else begin
            fb1 <= addr_out;
            fb2 <= fb1;
        end
    end
    assign pixel_in = fb2[PW-1:0];

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic          win;
        logic [PW-1:0] pix;
        int            stamp;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (latched at frame start)
    int            m_k      = 1;
    logic          m_locked = 1'b0;
    logic [PW-1:0] m_border = '0;
    logic          m_mir    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        active_in = 1'b0;
        hcount_in = '0;
        repeat (n) tick();
    endtask

    // One active pixel at display (line, col); expectation from plain division
    task automatic drive_px(input int line, input int col);
        exp_t        e;
        int          hs, vs;
        logic [31:0] a;
        hs = col / m_k;
        vs = line / m_k;
        a  = vs * SRC_W + (m_mir ? (SRC_W - 1 - hs) : hs);
        e.win   = m_locked && (col < SRC_W * m_k) && (line < SRC_H * m_k);
        e.pix   = e.win ? a[PW-1:0] : m_border;
        e.stamp = cyc;
        sb.push_back(e);
        active_in = 1'b1;
        hcount_in = 11'(col);
        tick();
    endtask

    task automatic run_line(input int line, input int width);
        for (int c = 0; c < width; c++) drive_px(line, c);
        idle(1);
    endtask

    // Drain the pipeline, then pulse frame_start_in and check scale_out update
    task automatic frame(input logic [1:0] sc, input logic [PW-1:0] bd, input logic mr);
        idle(LAT + 1);
        frame_start_in = 1'b1;
        scale_in       = sc;
        border_in      = bd;
        mirror_in      = mr;
        tick();
        frame_start_in = 1'b0;
        m_k      = int'(sc) + 1;
        m_locked = 1'b1;
        m_border = bd;
        m_mir    = MIR_BUILT && mr;
        check("scale_out_after_pulse", 32'(scale_out), 32'(sc));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"},   32'(addr_out),      0);
        check({tag, "_pixel"},  32'(pixel_out),     0);
        check({tag, "_valid"},  32'(valid_out),     0);
        check({tag, "_inwin"},  32'(in_window_out), 0);
        check({tag, "_scale"},  32'(scale_out),     0);
    endtask

    // Monitor: one scoreboard entry per presented output pixel
    always @(negedge clk_in) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: valid_out=1 with no expected pixel (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("in_window", 32'(in_window_out), 32'(e.win));
                check("pixel",     32'(pixel_out),     32'(e.pix));
                check("latency",   32'(cyc - e.stamp), LAT);
            end
        end
    end

    initial begin
        // Reset state, then unlocked lines: border 0, never in window
        repeat (2) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();
        run_line(0, 4);
        run_line(1, 4);

        // 1x (mirror requested: honoured only in mirror builds)
        frame(2'b00, 16'hF81F, 1'b1);
        for (int l = 0; l <= 321; l++)
            run_line(l, (l == 0 || l == 319) ? 242 : ((l == 320) ? 4 : 2));

        // 2x: window ends at column 480 and line 640
        frame(2'b01, 16'h07E0, 1'b0);
        for (int l = 0; l <= 641; l++)
            run_line(l, (l == 0 || l == 639) ? 482 : 4);

        // 4x: column 959 reads 239, column 960 and lines >= 1280 are border
        frame(2'b11, 16'h001F, 1'b0);
        for (int l = 0; l <= 1281; l++)
            run_line(l, (l == 0 || l == 1279) ? 962 : 2);

        // Mid-frame scale request is ignored until the next frame start
        frame(2'b00, 16'h1234, 1'b0);
        for (int l = 0; l <= 150; l++) begin
            if (l == 100) scale_in = 2'b10;
            run_line(l, 3);
        end
        idle(LAT + 1);
        check("scale_out_mid_frame", 32'(scale_out), 0);
        frame(2'b10, 16'h4321, 1'b0);
        for (int l = 0; l <= 961; l++)
            run_line(l, (l == 0 || l == 959) ? 722 : 2);

        // Reset asserted mid-line aborts at once and unlocks
        frame(2'b00, 16'hABCD, 1'b0);
        run_line(0, 3);
        drive_px(1, 0);
        drive_px(1, 1);
        #1;
        rst_n     = 1'b0;
        active_in = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        sb.delete();
        m_k      = 1;
        m_locked = 1'b0;
        m_border = '0;
        m_mir    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int l = 0; l < 4; l++) run_line(l, 6);
        frame(2'b00, 16'h5A5A, 1'b1);
        run_line(0, 4);
        run_line(1, 4);

        idle(LAT + 2);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
